// File: rtl/mem_to_wb.sv
// MEM/WB pipeline register: every MEM-stage field is registered once per clock and
// presented to writeback; a synchronous active-high reset clears the whole stage.
package mem_to_wb_pkg;
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC4  = 2'd3
  } wb_sel_e;
endpackage

module mem_to_wb
  import mem_to_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  wb_sel_e               MEM_WBSel_i,
  input  logic                  MEM_RegWrite_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_instruction_i,
  input  logic [DATA_WIDTH-1:0] MEM_rd_data_i,
  input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
  input  logic [DATA_WIDTH-1:0] MEM_addr_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  output wb_sel_e               WB_WBSel_o,
  output logic                  WB_RegWrite_o,
  output logic                  WB_MemWrite_o,
  output logic [DATA_WIDTH-1:0] WB_alu_result_o,
  output logic [DATA_WIDTH-1:0] WB_instruction_o,
  output logic [DATA_WIDTH-1:0] WB_rd_data_o,
  output logic [DATA_WIDTH-1:0] WB_pc_plus4_o,
  output logic [DATA_WIDTH-1:0] WB_addr_o,
  output logic [DATA_WIDTH-1:0] WB_wr_data_o
);

  typedef struct packed {
    wb_sel_e               wb_sel;
    logic                  reg_write;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d             = '0;
    stage_d.wb_sel      = MEM_WBSel_i;
    stage_d.reg_write   = MEM_RegWrite_i;
    stage_d.mem_write   = MEM_MemWrite_i;
    stage_d.alu_result  = MEM_alu_result_i;
    stage_d.instruction = MEM_instruction_i;
    stage_d.rd_data     = MEM_rd_data_i;
    stage_d.pc_plus4    = MEM_pc_plus4_i;
    stage_d.addr        = MEM_addr_i;
    stage_d.wr_data     = MEM_wr_data_i;
  end

  // rst_n is active-high despite its name; reset wins over capture.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stage_q        <= '0;
      stage_q.wb_sel <= WB_NONE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign WB_WBSel_o       = stage_q.wb_sel;
  assign WB_RegWrite_o    = stage_q.reg_write;
  assign WB_MemWrite_o    = stage_q.mem_write;
  assign WB_alu_result_o  = stage_q.alu_result;
  assign WB_instruction_o = stage_q.instruction;
  assign WB_rd_data_o     = stage_q.rd_data;
  assign WB_pc_plus4_o    = stage_q.pc_plus4;
  assign WB_addr_o        = stage_q.addr;
  assign WB_wr_data_o     = stage_q.wr_data;

endmodule

// File: tb/tb_mem_to_wb.sv
// Directed plus randomized bench for mem_to_wb against a snapshot-based reference model.
module tb_mem_to_wb;
  import mem_to_wb_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  wb_sel_e       sel;
  logic          rw, mw;
  logic [DW-1:0] alu, ins, rd, pc4, addr, wd;

  wb_sel_e       o_sel;
  logic          o_rw, o_mw;
  logic [DW-1:0] o_alu, o_ins, o_rd, o_pc4, o_addr, o_wd;

  // Model: the writeback stage shows what the MEM stage held at the last edge,
  // or the cleared state if that edge was a reset edge.
  wb_sel_e       e_sel;
  logic          e_rw, e_mw;
  logic [DW-1:0] e_alu, e_ins, e_rd, e_pc4, e_addr, e_wd;

  int checks = 0;
  int failures = 0;

  mem_to_wb #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_WBSel_i(sel), .MEM_RegWrite_i(rw), .MEM_MemWrite_i(mw),
    .MEM_alu_result_i(alu), .MEM_instruction_i(ins), .MEM_rd_data_i(rd),
    .MEM_pc_plus4_i(pc4), .MEM_addr_i(addr), .MEM_wr_data_i(wd),
    .WB_WBSel_o(o_sel), .WB_RegWrite_o(o_rw), .WB_MemWrite_o(o_mw),
    .WB_alu_result_o(o_alu), .WB_instruction_o(o_ins), .WB_rd_data_o(o_rd),
    .WB_pc_plus4_o(o_pc4), .WB_addr_o(o_addr), .WB_wr_data_o(o_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wbsel"}, DW'(o_sel), DW'(e_sel));
    chk({tag, ".regwr"}, DW'(o_rw),  DW'(e_rw));
    chk({tag, ".memwr"}, DW'(o_mw),  DW'(e_mw));
    chk({tag, ".alu"},   o_alu,  e_alu);
    chk({tag, ".instr"}, o_ins,  e_ins);
    chk({tag, ".rddata"},o_rd,   e_rd);
    chk({tag, ".pc4"},   o_pc4,  e_pc4);
    chk({tag, ".addr"},  o_addr, e_addr);
    chk({tag, ".wrdata"},o_wd,   e_wd);
  endtask

  task automatic drive(input wb_sel_e s, input logic r, input logic m,
                       input logic [DW-1:0] a, input logic [DW-1:0] i, input logic [DW-1:0] d,
                       input logic [DW-1:0] p, input logic [DW-1:0] ad, input logic [DW-1:0] w);
    sel = s; rw = r; mw = m; alu = a; ins = i; rd = d; pc4 = p; addr = ad; wd = w;
  endtask

  task automatic drive_random();
    drive(wb_sel_e'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Inputs are stable from here to the edge, so the model snapshots them now.
  task automatic step(input string tag);
    if (rst_n) begin
      e_sel = WB_NONE; e_rw = 1'b0; e_mw = 1'b0;
      e_alu = '0; e_ins = '0; e_rd = '0; e_pc4 = '0; e_addr = '0; e_wd = '0;
    end else begin
      e_sel = sel; e_rw = rw; e_mw = mw;
      e_alu = alu; e_ins = ins; e_rd = rd; e_pc4 = pc4; e_addr = addr; e_wd = wd;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(WB_NONE, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    #2;
    step("reset1");
    step("reset2");

    rst_n = 1'b0;
    drive(WB_ALU, 1'b1, 1'b1, 32'h12345678, 32'hABCDEF01, 32'hFEDCBA98,
          32'h00001004, 32'h00002000, 32'hAABBCCDD);
    step("capture");

    drive(WB_MEM, 1'b0, 1'b0, 32'h87654321, 32'h10FEDCBA, 32'h98765432,
          32'h00002008, 32'h00003000, 32'hEEFF0011);
    step("update");

    drive(WB_PC4, 1'b1, 1'b0, '0, '0, '0, 32'h00004004, '0, '0);
    step("mixzero");

    drive(WB_ALU, 1'b1, 1'b1, '1, '1, '1, '1, '1, '1);
    step("allones");

    // Mid-cycle input change must not reach the outputs before the edge.
    drive(WB_MEM, 1'b0, 1'b1, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003,
          32'h0BAD0004, 32'h0BAD0005, 32'h0BAD0006);
    #3;
    check_all("hold");
    drive(WB_PC4, 1'b1, 1'b0, 32'h11110000, 32'h22220000, 32'h33330000,
          32'h44440000, 32'h55550000, 32'h66660000);
    #2;
    check_all("hold2");
    step("latency");

    // A reset pulse that never spans an edge is ignored.
    drive(WB_ALU, 1'b0, 1'b1, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
          32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006);
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    step("glitchrst");

    drive(WB_MEM, 1'b1, 1'b1, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003,
          32'hDEAD0004, 32'hDEAD0005, 32'hDEAD0006);
    rst_n = 1'b1;
    step("midrst");
    rst_n = 1'b0;
    step("resume");

    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 9) == 0);
      drive_random();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_to_wb.md
MEM_TO_WB -- requirements
Module: mem_to_wb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the width of every data/address/instruction field.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-high (asserted = 1), sampled on the rising edge of clk.
REQ-004 MEM_WBSel_i  input  wb_sel_e  writeback source select from MEM stage (shared package enum: WB_NONE, WB_ALU, WB_MEM, WB_PC4).
REQ-005 MEM_RegWrite_i  input  1  register-file write enable.
REQ-006 MEM_MemWrite_i  input  1  data-memory write enable.
REQ-007 MEM_alu_result_i  input  DATA_WIDTH  ALU result.
REQ-008 MEM_instruction_i  input  DATA_WIDTH  instruction word.
REQ-009 MEM_rd_data_i  input  DATA_WIDTH  data read from memory.
REQ-010 MEM_pc_plus4_i  input  DATA_WIDTH  PC+4 of the instruction.
REQ-011 MEM_addr_i  input  DATA_WIDTH  memory address.
REQ-012 MEM_wr_data_i  input  DATA_WIDTH  memory write data.
REQ-013 WB_WBSel_o  output  wb_sel_e  registered MEM_WBSel_i.
REQ-014 WB_RegWrite_o, WB_MemWrite_o  output  1 each  registered enables.
REQ-015 WB_alu_result_o, WB_instruction_o, WB_rd_data_o, WB_pc_plus4_o, WB_addr_o, WB_wr_data_o  output  DATA_WIDTH each  registered copies of the like-named MEM_*_i inputs.
REQ-016 wb_sel_e is taken from the shared defines package; the block does not redefine its encoding.

Function
REQ-017 The block is a MEM/WB pipeline register: every WB_*_o output is driven directly from a flip-flop, with no combinational path from any input to any output.
REQ-018 Latency is exactly one clock: on each rising edge with rst_n deasserted, every WB_*_o takes the value its MEM_*_i input had just before that edge.
REQ-019 Between rising edges, outputs hold their value regardless of input changes.
REQ-020 All fields are captured unconditionally every cycle; no enable, stall or flush input exists.
REQ-021 Fields are passed bit-exact with no sign/zero extension, truncation or decoding; WB_MemWrite_o is passed through even though WB does not use it.
REQ-022 Fields are independent: any combination of input values, including all-zero and all-ones, is captured as-is.
REQ-023 Outputs are X-free after the first reset edge.

Reset
REQ-024 On a rising edge of clk with rst_n = 1: WB_WBSel_o = WB_NONE, WB_RegWrite_o = 0, WB_MemWrite_o = 0, and all six DATA_WIDTH outputs = 0.
REQ-025 Reset has priority over data capture; inputs presented on a reset edge are discarded.
REQ-026 Reset asserted mid-operation clears all outputs at the next rising edge; deassertion resumes capture on the first subsequent edge.
REQ-027 Asserting/deasserting rst_n between edges has no effect until the next rising edge.

Verification
REQ-028 Reset: rst_n = 1 for two edges, inputs all zero/WB_NONE -> all outputs zero, WB_WBSel_o = WB_NONE.
REQ-029 Capture: rst_n = 0, WBSel = WB_ALU, RegWrite = 1, MemWrite = 1, alu 0x12345678, instr 0xABCDEF01, rd_data 0xFEDCBA98, pc+4 0x00001004, addr 0x00002000, wr_data 0xAABBCCDD -> identical values on WB_*_o after one edge.
REQ-030 Update: WB_MEM, RegWrite = 0, MemWrite = 0, alu 0x87654321, instr 0x10FEDCBA, rd_data 0x98765432, pc+4 0x00002008, addr 0x00003000, wr_data 0xEEFF0011 -> all outputs follow after one edge, no residue from prior values.
REQ-031 Mixed zero: WB_PC4, RegWrite = 1, MemWrite = 0, pc+4 0x00004004, all other data 0 -> outputs match after one edge.
REQ-032 Hold/latency: change inputs mid-cycle -> outputs unchanged until the next edge, then equal the values sampled at that edge.
REQ-033 Reset mid-stream: with non-zero outputs, assert rst_n for one edge while non-zero inputs are present -> all outputs zero/WB_NONE; after deassertion, the next edge captures inputs.
